video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level
REQ-002 Ports SHALL be (name, direction, width, meaning):
- pix_clk, in, 1, pixel clock
- rst, in, 1, reset
- pattern_sel, in, 2, requested test pattern
- hs, out, 1, horizontal sync
- vs, out, 1, vertical sync
- de, out, 1, data enable
- r_out, out, 8, red, feeds downstream gamma stage
- g_out, out, 8, green, feeds downstream gamma stage
- b_out, out, 8, blue, feeds downstream gamma stage
- x_pos, out, 12, active pixel column
- y_pos, out, 12, active line
- frame_start, out, 1, first-pixel pulse
REQ-003 The block SHALL use one clock, pix_clk; rst SHALL be synchronous and active-high.

Function
REQ-004 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the four H parameters, 1650 default) and wrap to 0.
REQ-005 v_cnt SHALL increment only when h_cnt wraps; it SHALL count 0..V_TOTAL-1 (750 default) and wrap to 0 on the same cycle h_cnt wraps.
REQ-006 Timing order SHALL be: active, front porch, sync, back porch. Active is h_cnt < H_ACTIVE, or v_cnt < V_ACTIVE for lines.
REQ-007 de SHALL be high iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-008 hs SHALL equal HS_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-009 vs SHALL equal VS_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. vs is evaluated on the whole line, independent of h_cnt.
REQ-010 All outputs SHALL be registered and lag the counters by exactly 1 cycle. hs, vs, de, rgb, x_pos, y_pos and frame_start SHALL be mutually aligned.
REQ-011 x_pos/y_pos SHALL equal h_cnt/v_cnt when de=1, and SHALL hold 0 when de=0.
REQ-012 frame_start SHALL pulse for one cycle, coincident with de at pixel (0,0).
REQ-013 pattern_sel SHALL be sampled into pattern_q only on the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. Changes SHALL take effect from the next frame's first pixel, never mid-frame.
REQ-014 Pattern 0 (colour bars) SHALL use bar = x_pos / (H_ACTIVE/8), i.e. 160-pixel bars by default. Bars 0..7 SHALL be white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
REQ-015 Pattern 1 (horizontal ramp) SHALL set r=g=b=x_pos[7:0], wrapping every 256 pixels.
REQ-016 Pattern 2 (checkerboard) SHALL set r=g=b = (x_pos[5]^y_pos[5]) ? 255 : 0, giving 32-pixel squares.
REQ-017 Pattern 3 (vertical ramp) SHALL set r=g=b=y_pos[7:0].
REQ-018 r_out/g_out/b_out SHALL be 0 whenever de=0.

Reset
REQ-019 While rst=1, the block SHALL hold:
- h_cnt=0, v_cnt=0, pattern_q=0
- de=0, hs=~HS_POL, vs=~VS_POL
- rgb=0, x_pos=0, y_pos=0, frame_start=0
REQ-020 On the first cycle after rst falls, counters SHALL be at (0,0). The next cycle SHALL present de=1, frame_start=1, x_pos=0, y_pos=0.
REQ-021 rst asserted mid-frame SHALL abort the frame immediately. The restart SHALL follow REQ-020, with pattern_q=0 regardless of pattern_sel.

Verification
REQ-022 Reset release with pattern_sel=0 -> 2 cycles later: de=1, frame_start=1, rgb=FFFFFF. x_pos=159 -> FFFFFF; x_pos=160 -> FFFF00; x_pos=1279 -> 000000.
REQ-023 Free run of 2 frames -> per line: 1280 de-high cycles, hs high for 40 cycles starting 1390 cycles after line start. Per frame: vs high for 5 lines starting at line 725. Frame period SHALL be 1237500 cycles.
REQ-024 Pattern 1 -> x=255: rgb=FFFFFF; x=256: rgb=000000 (wrap). First blanking cycle (h_cnt=1280): rgb=0, x_pos=0.
REQ-025 pattern_sel changed 0->2 at line 300 -> the rest of the frame stays colour bars. The next frame is checkerboard: pixel (32,0)=FFFFFF, (32,32)=000000, (0,0)=000000.
REQ-026 rst pulsed for 1 cycle at line 400, pixel 600, with pattern_sel=3 -> outputs return to reset values. The frame restarts at (0,0) with colour bars. Pattern 3 appears from the following frame: line 300 -> rgb=2C2C2C.
REQ-027 HS_POL=0, VS_POL=0 -> hs/vs idle high and pulse low with identical timing to REQ-023.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Raster timing generator with four selectable test patterns; every output is registered one cycle behind h_cnt/v_cnt.
// Free-running with no backpressure. pattern_sel is only picked up at the end of a frame, so a frame never changes pattern partway through.
module video_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [1:0]  pattern_sel,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        frame_start
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_W    = 12'(H_ACTIVE / 8);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [1:0]  pattern_q;
  logic        h_wrap;
  logic        v_wrap;
  logic        active;
  logic        hs_nxt;
  logic        vs_nxt;
  logic [2:0]  bar;
  logic [23:0] rgb_nxt;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_nxt = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
  // vsync depends on the line number only, so it spans whole lines
  assign vs_nxt = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
  assign bar    = 3'(h_cnt / BAR_W);

  always_comb begin
    rgb_nxt = 24'h000000;
    if (active) begin
      unique case (pattern_q)
        2'd0: begin
          unique case (bar)
            3'd0: rgb_nxt = 24'hFFFFFF;
            3'd1: rgb_nxt = 24'hFFFF00;
            3'd2: rgb_nxt = 24'h00FFFF;
            3'd3: rgb_nxt = 24'h00FF00;
            3'd4: rgb_nxt = 24'hFF00FF;
            3'd5: rgb_nxt = 24'hFF0000;
            3'd6: rgb_nxt = 24'h0000FF;
            3'd7: rgb_nxt = 24'h000000;
          endcase
        end
        2'd1: rgb_nxt = {3{h_cnt[7:0]}};
        2'd2: rgb_nxt = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
        2'd3: rgb_nxt = {3{v_cnt[7:0]}};
      endcase
    end
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      pattern_q   <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
      end
      if (h_wrap && v_wrap) begin
        pattern_q <= pattern_sel;
      end
      de                    <= active;
      hs                    <= hs_nxt;
      vs                    <= vs_nxt;
      {r_out, g_out, b_out} <= rgb_nxt;
      x_pos                 <= active ? h_cnt : 12'd0;
      y_pos                 <= active ? v_cnt : 12'd0;
      frame_start           <= active && (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a small raster so several frames fit, run with both sync polarities side by side.
module tb_video_pattern_gen;

  localparam int HA = 288, HFP = 4, HSW = 4, HBP = 4;
  localparam int VA = 34, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
  } out_t;

  typedef struct {
    int          frame;
    int          x;
    int          y;
    logic [1:0]  sel;
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
  } vec_t;

  logic        pix_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic        hs_p, vs_p, de_p, fs_p;
  logic [7:0]  r_p, g_p, b_p;
  logic [11:0] x_p, y_p;
  logic        hs_n, vs_n, de_n, fs_n;
  logic [7:0]  r_n, g_n, b_n;
  logic [11:0] x_n, y_n;

  int checks = 0;
  int failures = 0;
  int m_t = 0, m_pat = 0, m_fr = 0;
  int last_t = -1, last_fr = -1;
  int per = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, hsn_cnt = 0, vsn_cnt = 0;
  bit have_prev = 1'b0;

  always #5 pix_clk = ~pix_clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_pos (
    .pix_clk(pix_clk), .rst(rst), .pattern_sel(pattern_sel),
    .hs(hs_p), .vs(vs_p), .de(de_p), .r_out(r_p), .g_out(g_p), .b_out(b_p),
    .x_pos(x_p), .y_pos(y_p), .frame_start(fs_p)
  );

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_neg (
    .pix_clk(pix_clk), .rst(rst), .pattern_sel(pattern_sel),
    .hs(hs_n), .vs(vs_n), .de(de_n), .r_out(r_n), .g_out(g_n), .b_out(b_n),
    .x_pos(x_n), .y_pos(y_n), .frame_start(fs_n)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (frame %0d t %0d)", name, got, exp, last_fr, last_t);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected outputs for raster position t (0 = first active pixel) under pattern pat; hs/vs are "asserted" flags.
  function automatic out_t ref_out(input int t, input int pat);
    out_t o;
    int x, y;
    logic [7:0] v;
    o = '0;
    x = t % HT;
    y = t / HT;
    o.hs = (x >= HA + HFP) && (x < HA + HFP + HSW);
    o.vs = (y >= VA + VFP) && (y < VA + VFP + VSW);
    if (x < HA && y < VA) begin
      o.de = 1'b1;
      o.fs = (t == 0);
      o.x  = 12'(x);
      o.y  = 12'(y);
      case (pat)
        0: o.rgb = bar_colour(x / (HA / 8));
        1: begin v = 8'(x % 256); o.rgb = {v, v, v}; end
        2: o.rgb = ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
        default: begin v = 8'(y % 256); o.rgb = {v, v, v}; end
      endcase
    end
    return o;
  endfunction

  task automatic frame_stats();
    if (rst) begin
      have_prev = 1'b0;
      return;
    end
    if (fs_p) begin
      if (have_prev) begin
        chk("frame_period", 64'(per), 64'(FRAME));
        chk("frame_de_cycles", 64'(de_cnt), 64'(HA * VA));
        chk("frame_hs_cycles", 64'(hs_cnt), 64'(HSW * VT));
        chk("frame_vs_cycles", 64'(vs_cnt), 64'(VSW * HT));
        chk("frame_hs_low_neg", 64'(hsn_cnt), 64'(HSW * VT));
        chk("frame_vs_low_neg", 64'(vsn_cnt), 64'(VSW * HT));
      end
      have_prev = 1'b1;
      per = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; hsn_cnt = 0; vsn_cnt = 0;
    end
    per++;
    de_cnt  += int'(de_p);
    hs_cnt  += int'(hs_p);
    vs_cnt  += int'(vs_p);
    hsn_cnt += int'(!hs_n);
    vsn_cnt += int'(!vs_n);
  endtask

  task automatic step(input logic r, input logic [1:0] s);
    out_t e;
    rst = r;
    pattern_sel = s;
    @(posedge pix_clk);
    if (r) begin
      e = '0;
      m_t = 0; m_pat = 0; m_fr = 0;
      last_t = -1; last_fr = -1;
    end else begin
      e = ref_out(m_t, m_pat);
      last_t = m_t;
      last_fr = m_fr;
      if (m_t == FRAME - 1) begin
        m_pat = int'(s);
        m_t = 0;
        m_fr++;
      end else begin
        m_t++;
      end
    end
    #1;
    chk("cycle_pos", 64'({de_p, hs_p, vs_p, fs_p, r_p, g_p, b_p, x_p, y_p}), 64'(e));
    chk("cycle_neg", 64'({de_n, ~hs_n, ~vs_n, fs_n, r_n, g_n, b_n, x_n, y_n}), 64'(e));
    frame_stats();
  endtask

  // Runs until the output cycle for pixel (x,y) of frame f has been presented.
  task automatic goto_px(input int f, input int x, input int y, input logic [1:0] s);
    int n;
    n = 0;
    do begin
      step(1'b0, s);
      n++;
    end while (!(last_fr == f && last_t == y * HT + x) && n < 3 * FRAME);
    if (n >= 3 * FRAME) begin
      failures++;
      $display("FAIL goto_timeout frame=%0d x=%0d y=%0d", f, x, y);
    end
  endtask

  vec_t tbl[24];

  initial begin
    tbl[0]  = '{0,   0,  0, 2'd0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{0,  35,  0, 2'd0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{0,  36,  0, 2'd0, 24'hFFFF00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{0, 100,  3, 2'd0, 24'h00FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{0, 287,  5, 2'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{0, 288,  5, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{0, 100, 36, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1,  10,  2, 2'd1, 24'h0A0A0A, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1, 255,  2, 2'd1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1, 256,  2, 2'd1, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1,  50, 25, 2'd2, 24'h323232, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2,   0,  0, 2'd2, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{2,  32,  0, 2'd2, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{2,   0, 32, 2'd2, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{2,  32, 32, 2'd2, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{3, 291, 10, 2'd3, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{3, 292, 10, 2'd3, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{3, 295, 10, 2'd3, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{3, 296, 10, 2'd3, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{3,   5, 30, 2'd3, 24'h1E1E1E, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{3, 287, 33, 2'd3, 24'h212121, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{3,   0, 35, 2'd3, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{3, 299, 37, 2'd3, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{4, 100, 20, 2'd3, 24'h141414, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) step(1'b1, 2'd3);
    chk("rst_de", 64'(de_p), 64'(0));
    chk("rst_hs_pos", 64'(hs_p), 64'(0));
    chk("rst_vs_pos", 64'(vs_p), 64'(0));
    chk("rst_hs_neg", 64'(hs_n), 64'(1));
    chk("rst_vs_neg", 64'(vs_n), 64'(1));
    chk("rst_rgb_xy", 64'({r_p, g_p, b_p, x_p, y_p, fs_p}), 64'(0));

    for (int i = 0; i < 24; i++) begin
      goto_px(tbl[i].frame, tbl[i].x, tbl[i].y, tbl[i].sel);
      chk($sformatf("vec%0d", i),
          64'({de_p, hs_p, vs_p, fs_p, r_p, g_p, b_p, x_p, y_p}),
          64'({tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].rgb,
               tbl[i].de ? 12'(tbl[i].x) : 12'd0, tbl[i].de ? 12'(tbl[i].y) : 12'd0}));
    end

    // One-cycle reset mid-frame with pattern 3 requested: restart must use colour bars.
    step(1'b1, 2'd3);
    chk("midrst_de", 64'(de_p), 64'(0));
    chk("midrst_hs_neg", 64'(hs_n), 64'(1));
    chk("midrst_rgb_xy", 64'({r_p, g_p, b_p, x_p, y_p, fs_p}), 64'(0));
    step(1'b0, 2'd3);
    chk("restart_first_px", 64'({de_p, fs_p, r_p, g_p, b_p, x_p, y_p}),
        64'({1'b1, 1'b1, 24'hFFFFFF, 12'd0, 12'd0}));

    // Random pattern requests through the frame; 3 is held at the frame boundary.
    begin
      int n;
      logic [1:0] s;
      n = 0;
      do begin
        s = (m_t == FRAME - 1) ? 2'd3 : 2'($urandom_range(0, 3));
        step(1'b0, s);
        n++;
      end while (!(last_fr == 1 && last_t == 30 * HT + 5) && n < 3 * FRAME);
      if (n >= 3 * FRAME) begin
        failures++;
        $display("FAIL random_run_timeout");
      end
      chk("post_rst_vramp", 64'({de_p, r_p, g_p, b_p}), 64'({1'b1, 24'h1E1E1E}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
